// File: rtl/seg7_scan_if.sv
// seg7_scan_if: signal bundle between the GPIO display registers and the
// seven-segment scanner.
//   value    : 4*NUM_DIGITS hex nibbles, digit k = value[4k+3:4k]
//   dp       : decimal point per digit, 1 = lit
//   digit_en : 1 = digit displayed
//   load     : strobe capturing value/dp/digit_en into the pending buffer
//   pending  : pending buffer holds uncommitted data
//   frame    : one-cycle pulse when the digit index wraps to 0
//   SEG/DP/AN: segment cathodes (bit0=a .. bit6=g), decimal point, anodes
// master = register side (drives data), slave = scanner.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic                    pending;
    logic                    frame;
    logic [6:0]              SEG;
    logic                    DP;
    logic [NUM_DIGITS-1:0]   AN;

    modport master (
        output value, dp, digit_en, load,
        input  pending, frame, SEG, DP, AN
    );

    modport slave (
        input  value, dp, digit_en, load,
        output pending, frame, SEG, DP, AN
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment scanner with a
// double-buffered display word that only commits at frame boundaries.
// Ports:
//   HCLK    : system clock
//   HRESET  : synchronous reset, active-high
//   bus     : seg7_scan_if.slave (value/dp/digit_en/load in,
//             pending/frame/SEG/DP/AN out)
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 always shown, a lit dp keeps a digit visible).
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input logic       HCLK,
    input logic       HRESET,
    seg7_scan_if.slave bus
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [PW-1:0] prescaler;
    logic [IW-1:0] index;
    logic          pend_q;
    logic          frame_q;

    logic [NUM_DIGITS-1:0][3:0] pb_nib, sh_nib;
    logic [NUM_DIGITS-1:0]      pb_en, sh_en;
    logic [NUM_DIGITS-1:0]      pb_dp, sh_dp;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; disabled digits neither
    // show nor break a run of leading zeros.
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (sh_en[k]) begin
                zero_above  = zero_above & (sh_nib[k] == 4'd0);
                lz_blank[k] = zero_above & ~sh_dp[k] & (k != 0);
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Next output values in active-high form, computed from the current
    // scan position; registered below, giving one cycle of latency.
    always_comb begin
        an_n  = '0;
        seg_n = '0;
        dp_n  = 1'b0;
        if (sh_en[index]) begin
            seg_n = hex7(sh_nib[index]);
            dp_n  = sh_dp[index];
            if (prescaler >= P_BLANK && !lz_blank[index]) begin
                an_n[index] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            prescaler <= '0;
            index     <= '0;
            pend_q    <= 1'b0;
            frame_q   <= 1'b0;
            pb_nib    <= '0;
            pb_en     <= '0;
            pb_dp     <= '0;
            sh_nib    <= '0;
            sh_en     <= '0;
            sh_dp     <= '0;
            an_q      <= {NUM_DIGITS{INV}};
            seg_q     <= {7{INV}};
            dp_q      <= INV;
        end else begin
            frame_q <= 1'b0;
            if (prescaler == P_LAST) begin
                prescaler <= '0;
                if (index == I_LAST) begin
                    index   <= '0;
                    frame_q <= 1'b1;
                    if (pend_q) begin
                        sh_nib <= pb_nib;
                        sh_en  <= pb_en;
                        sh_dp  <= pb_dp;
                        pend_q <= 1'b0;
                    end
                end else begin
                    index <= index + IW'(1);
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            // Placed after the commit so a same-cycle load keeps pending set
            // while the commit still takes the old buffer contents.
            if (bus.load) begin
                pb_nib <= bus.value;
                pb_en  <= bus.digit_en;
                pb_dp  <= bus.dp;
                pend_q <= 1'b1;
            end

            an_q  <= an_n ^ {NUM_DIGITS{INV}};
            seg_q <= seg_n ^ {7{INV}};
            dp_q  <= dp_n ^ INV;
        end
    end

    assign bus.pending = pend_q;
    assign bus.frame   = frame_q;
    assign bus.SEG     = seg_q;
    assign bus.DP      = dp_q;
    assign bus.AN      = an_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with
// NUM_DIGITS=8, PRESCALE=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
// Expected outputs are queued tagged with the cycle number n (posedges
// since reset release); a negedge monitor pops and compares matching
// entries. Honours SEG7_LEADING_ZERO_BLANK_EN in its expectations.
module tb_seg7_scan_driver;
    logic HCLK = 1'b0;
    logic HRESET;

    seg7_scan_if #(.NUM_DIGITS(8)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (8),
        .PRESCALE    (4),
        .BLANK_CYCLES(1),
        .ACTIVE_LOW  (1)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int         n;
        bit         kind;   // 0 = display outputs, 1 = pending only
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frm;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;
    bit   mon_on = 1'b0;

    always @(posedge HCLK) begin
        if (HRESET) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s n=%0d got=%h want=%h", name, n, act, want);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Frame f shows the shadow committed at edge 32f; its outputs appear at
    // samples 32f+1 .. 32f+32, each reflecting the scan position one cycle earlier.
    task automatic push_frame(input int f, input logic [31:0] v,
                              input logic [7:0] en, input logic [7:0] d);
        logic [7:0] vis;
        bit   allz;
        int   pv, p, i;
        exp_t e;
        vis = en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int j = 1; j < 8; j++) begin
            allz = 1'b1;
            for (int k = j; k < 8; k++)
                if (en[k] && v[4*k +: 4] != 4'h0) allz = 1'b0;
            if (en[j] && allz && !d[j]) vis[j] = 1'b0;
        end
`endif
        for (int m = 32*f + 1; m <= 32*f + 32; m++) begin
            pv     = m - 1;
            p      = pv % 4;
            i      = (pv / 4) % 8;
            e.n    = m;
            e.kind = 1'b0;
            e.an   = (p >= 1 && vis[i]) ? ~(8'd1 << i) : 8'hFF;
            e.seg  = en[i] ? ~hexseg(v[4*i +: 4]) : 7'h7F;
            e.dp   = en[i] ? ~d[i] : 1'b1;
            e.frm  = (m % 32 == 0);
            e.pend = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_pend(input int m, input logic p);
        exp_t e;
        e.n = m; e.kind = 1'b1; e.an = '0; e.seg = '0; e.dp = 1'b0; e.frm = 1'b0; e.pend = p;
        q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        if (mon_on) begin
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (q[j].n == n) begin
                    if (q[j].kind) begin
                        chk("pending", 32'(bus.pending), 32'(q[j].pend));
                    end else begin
                        chk("AN", 32'(bus.AN), 32'(q[j].an));
                        chk("SEG", 32'(bus.SEG), 32'(q[j].seg));
                        chk("DP", 32'(bus.DP), 32'(q[j].dp));
                        chk("frame", 32'(bus.frame), 32'(q[j].frm));
                    end
                    q.delete(j);
                end else if (q[j].n < n) begin
                    chk("missed_sample", 32'(n), 32'(q[j].n));
                    q.delete(j);
                end
            end
        end
    end

    task automatic wait_n(input int k);
        int guard;
        guard = 0;
        while (n < k && guard < 1000) begin
            @(negedge HCLK);
            guard++;
        end
        if (n != k) chk("wait_timeout", 32'(n), 32'(k));
    endtask

    // Drives load during cycle n=k-1 so it is captured at edge k.
    task automatic load_at(input int k, input logic [31:0] v,
                           input logic [7:0] en, input logic [7:0] d);
        wait_n(k - 1);
        bus.value    = v;
        bus.digit_en = en;
        bus.dp       = d;
        bus.load     = 1'b1;
        @(negedge HCLK);
        bus.load     = 1'b0;
    endtask

    initial begin
        HRESET       = 1'b1;
        bus.value    = '0;
        bus.dp       = '0;
        bus.digit_en = '0;
        bus.load     = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_AN", 32'(bus.AN), 32'h FF);
        chk("rst_SEG", 32'(bus.SEG), 32'h7F);
        chk("rst_DP", 32'(bus.DP), 32'h1);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_frame", 32'(bus.frame), 32'h0);

        push_frame(0, 32'h0000_0000, 8'h00, 8'h00);
        push_frame(1, 32'h7654_3210, 8'hFF, 8'h00);
        push_frame(2, 32'hFFFF_FFFF, 8'hFF, 8'h00);
        push_frame(3, 32'h89AB_CDEF, 8'hFF, 8'h81);
        push_frame(4, 32'h9876_5A43, 8'h05, 8'h04);
        push_frame(5, 32'h0000_0120, 8'hFF, 8'h00);
        push_frame(6, 32'h0000_0000, 8'hFF, 8'h00);
        push_pend(1, 1'b1);   push_pend(31, 1'b1);  push_pend(32, 1'b0);
        push_pend(40, 1'b1);  push_pend(63, 1'b1);  push_pend(64, 1'b0);
        push_pend(80, 1'b1);  push_pend(96, 1'b1);  push_pend(127, 1'b1);
        push_pend(128, 1'b0); push_pend(140, 1'b1); push_pend(160, 1'b0);
        push_pend(170, 1'b1); push_pend(192, 1'b0);

        mon_on = 1'b1;
        HRESET = 1'b0;

        load_at(1,   32'h7654_3210, 8'hFF, 8'h00);
        load_at(40,  32'hFFFF_FFFF, 8'hFF, 8'h00);
        load_at(80,  32'h89AB_CDEF, 8'hFF, 8'h81);
        load_at(96,  32'h9876_5A43, 8'h05, 8'h04);  // lands on the wrap edge
        load_at(140, 32'h0000_0120, 8'hFF, 8'h00);
        load_at(170, 32'h0000_0000, 8'hFF, 8'h00);
        wait_n(226);
        mon_on = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'h0);

        // Reset mid-scan with a load in the same cycle: the load is dropped.
        HRESET       = 1'b1;
        bus.value    = 32'h1234_5678;
        bus.digit_en = 8'hFF;
        bus.dp       = 8'hFF;
        bus.load     = 1'b1;
        @(negedge HCLK);
        bus.load = 1'b0;
        chk("rst2_pending", 32'(bus.pending), 32'h0);
        chk("rst2_AN", 32'(bus.AN), 32'hFF);
        chk("rst2_frame", 32'(bus.frame), 32'h0);
        HRESET = 1'b0;
        repeat (10) @(negedge HCLK);
        chk("post_rst_AN", 32'(bus.AN), 32'hFF);
        chk("post_rst_SEG", 32'(bus.SEG), 32'h7F);
        chk("post_rst_pending", 32'(bus.pending), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
